// File: rtl/somador.sv
// somador: SIZE-bit ripple-carry adder, S = X + Y + Cin, with a registered copy.
//
// Ports
//   clk     in   rising-edge clock, used only by the registered outputs
//   rst_n   in   asynchronous active-low reset, clears the registered outputs only
//   X, Y    in   SIZE-bit operands
//   Cin     in   carry-in (set with an inverted Y to subtract)
//   S       out  combinational sum, (X + Y + Cin) mod 2^SIZE
//   Cout    out  combinational carry out of the MSB
//   Ovf     out  combinational signed overflow (carry into MSB ^ carry out of MSB)
//   Zero    out  combinational, 1 when S == 0
//   S_q, Cout_q, Ovf_q, Zero_q
//           out  the combinational outputs captured on each rising clk edge
module somador #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] X,
  input  logic [SIZE-1:0] Y,
  input  logic            Cin,
  output logic [SIZE-1:0] S,
  output logic            Cout,
  output logic            Ovf,
  output logic            Zero,
  output logic [SIZE-1:0] S_q,
  output logic            Cout_q,
  output logic            Ovf_q,
  output logic            Zero_q
);

  // carry[i] is the carry into bit i; carry[SIZE] is the carry out of the MSB.
  logic [SIZE:0]   carry;
  logic [SIZE-1:0] sum;

  assign carry[0] = Cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum[i]     = X[i] ^ Y[i] ^ carry[i];
    assign carry[i+1] = (X[i] & Y[i]) | (carry[i] & (X[i] ^ Y[i]));
  end

  assign S    = sum;
  assign Cout = carry[SIZE];
  assign Ovf  = carry[SIZE] ^ carry[SIZE-1];
  assign Zero = ~|sum;

  // Registered copy: no enable, one cycle of latency.
  logic [SIZE-1:0] sum_d, sum_q;
  logic            cout_d, cout_q;
  logic            ovf_d, ovf_q;
  logic            zero_d, zero_q;

  always_comb begin
    sum_d  = S;
    cout_d = Cout;
    ovf_d  = Ovf;
    zero_d = Zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;  // reads 0 while in reset even though sum_q is 0
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign S_q    = sum_q;
  assign Cout_q = cout_q;
  assign Ovf_q  = ovf_q;
  assign Zero_q = zero_q;

endmodule

// File: tb/tb_somador.sv
// Self-checking bench for somador (SIZE = 32).
module tb_somador;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x, y;
  logic         cin;
  logic [W-1:0] s, s_q;
  logic         cout, ovf, zero, cout_q, ovf_q, zero_q;

  int n_checks;
  int n_pass;

  // Expected {Cout, Ovf, Zero, S} per captured cycle.
  logic [W+2:0] sb_q[$];

  somador #(.SIZE(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .X      (x),
    .Y      (y),
    .Cin    (cin),
    .S      (s),
    .Cout   (cout),
    .Ovf    (ovf),
    .Zero   (zero),
    .S_q    (s_q),
    .Cout_q (cout_q),
    .Ovf_q  (ovf_q),
    .Zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from wide arithmetic and operand signs.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {full[W], v, (full[W-1:0] == '0), full[W-1:0]};
  endfunction

  // Directed vectors: X, Y, Cin, S, Cout, Ovf, Zero
  localparam int ND = 6;
  localparam logic [W-1:0] DX [ND] = '{32'h000001F4, 32'h000001F4, 32'h000003B6,
                                       32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  localparam logic [W-1:0] DY [ND] = '{32'hFFFFFE3E, 32'h000001C2, 32'hFFFFFC18,
                                       32'h00000001, 32'h00000000, 32'h80000000};
  localparam logic         DC [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [W-1:0] DS [ND] = '{32'h00000032, 32'h000003B6, 32'hFFFFFFCE,
                                       32'h80000000, 32'h00000000, 32'h00000000};
  localparam logic         DCO[ND] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic         DOV[ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic         DZ [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_directed();
    for (int i = 0; i < ND; i++) begin
      x = DX[i]; y = DY[i]; cin = DC[i];
      #1;
      n_checks++;
      if ({cout, ovf, zero, s} !== {DCO[i], DOV[i], DZ[i], DS[i]})
        $display("FAIL directed[%0d]: got S=%h Cout=%b Ovf=%b Zero=%b, want S=%h Cout=%b Ovf=%b Zero=%b",
                 i, s, cout, ovf, zero, DS[i], DCO[i], DOV[i], DZ[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    // Load a nonzero result, then assert reset between edges.
    rst_n = 1'b1; x = 32'h1F4; y = 32'h1C2; cin = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (s_q !== 32'h3B6) $display("FAIL preload_s_q: got %h want %h", s_q, 32'h3B6);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_q, cout_q, ovf_q, zero_q} !== '0)
      $display("FAIL reset_async: got S_q=%h Cout_q=%b Ovf_q=%b Zero_q=%b want all 0",
               s_q, cout_q, ovf_q, zero_q);
    else n_pass++;
    // Held through an edge with all-ones sum inputs.
    x = 32'hFFFFFFFF; y = 32'h0; cin = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({s_q, cout_q, ovf_q, zero_q} !== '0)
      $display("FAIL reset_held: got S_q=%h Cout_q=%b Ovf_q=%b Zero_q=%b want all 0",
               s_q, cout_q, ovf_q, zero_q);
    else n_pass++;
    // Combinational path is live during reset.
    n_checks++;
    if ({cout, zero, s} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL comb_in_reset: got S=%h Cout=%b Zero=%b want S=0 Cout=1 Zero=1",
               s, cout, zero);
    else n_pass++;
  endtask

  task automatic test_release();
    // First edge after release captures the current inputs.
    x = 32'h1F4; y = 32'h1C2; cin = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({s_q, cout_q, ovf_q, zero_q} !== {32'h3B6, 1'b0, 1'b0, 1'b0})
      $display("FAIL release_first_edge: got S_q=%h Cout_q=%b Ovf_q=%b Zero_q=%b want 3b6/0/0/0",
               s_q, cout_q, ovf_q, zero_q);
    else n_pass++;
  endtask

  task automatic test_back_to_back(input int n);
    logic [W+2:0] exp_v, got_v;
    for (int i = 0; i < n; i++) begin
      x = $urandom(); y = $urandom(); cin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: y = -(x + {31'b0, cin});        // forces a zero sum
        1: x = 32'h7FFFFFFF;
        2: x = 32'h80000000;
        3: y = 32'hFFFFFFFF;
        default: ;
      endcase
      #1;
      exp_v = model(x, y, cin);
      n_checks++;
      if ({cout, ovf, zero, s} !== exp_v)
        $display("FAIL comb_rand[%0d]: X=%h Y=%h Cin=%b got %h want %h",
                 i, x, y, cin, {cout, ovf, zero, s}, exp_v);
      else n_pass++;
      sb_q.push_back(exp_v);
      @(posedge clk); #1;
      got_v = {cout_q, ovf_q, zero_q, s_q};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got_v !== exp_v)
        $display("FAIL reg_rand[%0d]: got %h want %h", i, got_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d left want 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    x = '0; y = '0; cin = 1'b0;
    #1;
    test_directed();
    test_reset();
    test_release();
    test_back_to_back(10000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
